// File: rtl/instr_fetch.sv
// instr_fetch
// -----------
// Instruction fetch front-end sitting directly upstream of the synchronous
// program ROM. It drives a word address to the ROM every cycle. It captures
// the returned word one cycle later. Fetched words are buffered in a small
// FIFO and handed to decode over a valid/ready handshake. A redirect pulse
// flushes everything in flight and restarts fetch at the new PC.
//
// Parameters:
//   RESET_PC        first PC fetched after reset (word-aligned)
//   DEPTH           instruction buffer entries (>= 2 for one instr per cycle)
//
// Ports:
//   clk             system clock, rising-edge active
//   rst             asynchronous active-high reset
//   ia              instruction address to the ROM (registered by the ROM)
//   rom_data        ROM read data for the previous cycle's ia
//   redirect_valid  single-cycle flush/restart pulse
//   redirect_pc     restart PC, low two bits ignored
//   instr_valid     instr/instr_pc hold a valid instruction
//   instr_ready     decode accepts when instr_valid & instr_ready
//   instr           instruction word at the head of the buffer
//   instr_pc        address of instr

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ia,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_fetch;
    logic          inflight;
    logic [31:0]   inflight_pc;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic          issue;
    logic [31:0]   occupancy;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign ia          = pc_fetch;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    assign push        = inflight & ~redirect_valid;

    // Occupancy after this cycle's pop. Buffered words and the word still
    // in the ROM both hold a slot, so a push can never meet a full buffer.
    assign occupancy = 32'(count) + 32'(inflight) - 32'(pop);
    assign issue     = ~redirect_valid && (occupancy < 32'(DEPTH));

    // The head comes straight from registered storage. It is forced to zero
    // when the buffer is empty, so reset and flush present clean outputs.
    assign instr    = instr_valid ? word_mem[rd_ptr] : '0;
    assign instr_pc = instr_valid ? pc_mem[rd_ptr]   : '0;

    // Fetch PC and in-flight tracking. A redirect drops the outstanding ROM
    // response and does not issue in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_fetch    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc_fetch    <= redirect_pc & ~32'h3;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc_fetch;
                pc_fetch    <= pc_fetch + 32'd4;
            end
        end
    end

    // Buffer pointers and count. A redirect empties the buffer. A handshake
    // in the redirect cycle has already been seen by the consumer, so no
    // special handling is needed for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage. It needs no reset because the outputs are gated by
    // count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            word_mem[wr_ptr] <= rom_data;
        end
    end

endmodule
